// File: rtl/clock_ui_pkg.sv
// clock_ui_pkg: repeat-FSM states and default timing shared by the clock UI front end
package clock_ui_pkg;
  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} rep_state_e;
  localparam int DEF_DEBOUNCE_CYCLES = 500_000;
  localparam int DEF_QUARTER_CYCLES  = 12_500_000;
  localparam int DEF_HOLD_QUARTERS   = 4;
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/button_tick_conditioner_if.sv
// button_tick_conditioner_if: raw buttons in, conditioned strobes and timebase out
interface button_tick_conditioner_if;
  logic btn_set;
  logic btn_up;
  logic btn_down;
  logic pulsed_set;
  logic pulsed_up;
  logic pulsed_down;
  logic real_quarter;
  logic real_clk;
  modport master (
    output btn_set, btn_up, btn_down,
    input  pulsed_set, pulsed_up, pulsed_down, real_quarter, real_clk
  );
  modport slave (
    input  btn_set, btn_up, btn_down,
    output pulsed_set, pulsed_up, pulsed_down, real_quarter, real_clk
  );
endinterface

// File: rtl/debounce_oneshot.sv
// debounce_oneshot: 2-flop synchroniser, hold-time debounce and registered press strobe
module debounce_oneshot
  import clock_ui_pkg::*;
#(
  parameter int CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_stable,
  output logic o_press,
  output logic o_rise
);
  localparam int W = cnt_w(CYCLES);
  logic         r_s1;
  logic         r_s2;
  logic         r_stable;
  logic         r_stable_d;
  logic         r_press;
  logic [W-1:0] r_cnt;
  logic         w_diff;
  logic         w_hit;
  assign w_diff = r_s2 != r_stable;
  assign w_hit  = w_diff && r_cnt == W'(CYCLES - 1);
  // o_rise is the press strobe one cycle early, so the repeat FSM can act on the same edge
  assign o_rise   = r_stable & ~r_stable_d;
  assign o_stable = r_stable;
  assign o_press  = r_press;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_stable   <= 1'b0;
      r_stable_d <= 1'b0;
      r_press    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_s1       <= i_btn;
      r_s2       <= r_s1;
      r_stable_d <= r_stable;
      r_press    <= o_rise;
      r_cnt      <= (!w_diff || w_hit) ? '0 : r_cnt + W'(1);
      if (w_hit) r_stable <= r_s2;
    end
  end
endmodule

// File: rtl/button_tick_conditioner.sv
// button_tick_conditioner: debounced button strobes with up/down auto-repeat and 4 Hz / 1 Hz timebase
module button_tick_conditioner
  import clock_ui_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int QUARTER_CYCLES  = DEF_QUARTER_CYCLES,
  parameter int HOLD_QUARTERS   = DEF_HOLD_QUARTERS
) (
  input logic                      clk,
  input logic                      reset,
  button_tick_conditioner_if.slave bus
);
  localparam int QW = cnt_w(QUARTER_CYCLES);
  localparam int HW = cnt_w(HOLD_QUARTERS + 1);
  localparam logic [QW-1:0] QLAST = QW'(QUARTER_CYCLES - 1);
  localparam logic [HW-1:0] HQ    = HW'(HOLD_QUARTERS);
  logic [QW-1:0] r_qcnt;
  logic [QW-1:0] w_qnext;
  logic [1:0]    r_qidx;
  logic [1:0]    w_qidx;
  logic          r_quarter;
  logic          r_rclk;
  logic          w_qtick;
  logic [1:0]    w_stab;
  logic [1:0]    w_press;
  logic [1:0]    w_rise;
  logic [1:0]    w_rep;
  logic          w_both;
  logic          w_set_stable;
  logic          w_set_press;
  logic          w_set_rise;
  logic          w_unused;
  debounce_oneshot #(.CYCLES(DEBOUNCE_CYCLES)) u_set (
    .clk(clk), .reset(reset), .i_btn(bus.btn_set),
    .o_stable(w_set_stable), .o_press(w_set_press), .o_rise(w_set_rise)
  );
  debounce_oneshot #(.CYCLES(DEBOUNCE_CYCLES)) u_up (
    .clk(clk), .reset(reset), .i_btn(bus.btn_up),
    .o_stable(w_stab[0]), .o_press(w_press[0]), .o_rise(w_rise[0])
  );
  debounce_oneshot #(.CYCLES(DEBOUNCE_CYCLES)) u_down (
    .clk(clk), .reset(reset), .i_btn(bus.btn_down),
    .o_stable(w_stab[1]), .o_press(w_press[1]), .o_rise(w_rise[1])
  );
  assign w_unused = &{1'b0, w_set_stable, w_set_rise};
  // w_qtick is high the cycle before real_quarter, keeping both strobes registered
  assign w_qnext = (r_qcnt == QLAST) ? '0 : r_qcnt + QW'(1);
  assign w_qtick = w_qnext == QLAST;
  assign w_qidx  = r_qidx + {1'b0, r_quarter};
  assign w_both  = &w_stab;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_qcnt    <= '0;
      r_qidx    <= '0;
      r_quarter <= 1'b0;
      r_rclk    <= 1'b0;
    end else begin
      r_qcnt    <= w_qnext;
      r_qidx    <= w_qidx;
      r_quarter <= w_qtick;
      r_rclk    <= w_qtick && w_qidx == 2'd3;
    end
  end
  for (genvar i = 0; i < 2; i++) begin : g_rep
    rep_state_e    r_st;
    rep_state_e    w_st;
    logic [HW-1:0] r_h;
    logic [HW-1:0] w_h;
    logic          w_fire;
    logic          r_rep;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_st  <= IDLE;
        r_h   <= '0;
        r_rep <= 1'b0;
      end else begin
        r_st  <= w_st;
        r_h   <= w_h;
        r_rep <= w_fire;
      end
    end
    always_comb begin
      w_st   = r_st;
      w_h    = r_h;
      w_fire = 1'b0;
      case (r_st)
        IDLE: if (w_rise[i]) begin
          w_st = HOLD;
          w_h  = '0;
        end
        HOLD: if (w_qtick) begin
          w_h = r_h + HW'(1);
          if (w_h == HQ) begin
            w_st   = REPEAT;
            w_fire = 1'b1;
          end
        end
        REPEAT: w_fire = w_qtick;
        default: w_st = IDLE;
      endcase
      // release, or both up and down held, cancels any repeat immediately
      if (!w_stab[i] || w_both) begin
        w_st   = IDLE;
        w_fire = 1'b0;
      end
    end
    assign w_rep[i] = r_rep;
  end
  assign bus.pulsed_set   = w_set_press;
  assign bus.pulsed_up    = w_press[0] | w_rep[0];
  assign bus.pulsed_down  = w_press[1] | w_rep[1];
  assign bus.real_quarter = r_quarter;
  assign bus.real_clk     = r_rclk;
endmodule

// File: tb/tb_button_tick_conditioner.sv
// tb_button_tick_conditioner: directed checks of debounce, strobes, auto-repeat and timebase
module tb_button_tick_conditioner;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int n_set, n_up, n_dn, n0;
  int set_cy[16];
  int up_cy[16];
  int dn_cy[16];
  button_tick_conditioner_if bus();
  button_tick_conditioner #(
    .DEBOUNCE_CYCLES(4), .QUARTER_CYCLES(8), .HOLD_QUARTERS(2)
  ) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk or posedge reset) cyc <= reset ? 0 : cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
    if (reset)
      check("reset_out", 32'({bus.pulsed_set, bus.pulsed_up, bus.pulsed_down, bus.real_quarter, bus.real_clk}), 0);
    else
      check("timebase", 32'({bus.real_quarter, bus.real_clk}), 32'({cyc % 8 == 7, cyc % 32 == 31}));
    if (bus.pulsed_set) begin
      if (n_set < 16) set_cy[n_set] = cyc;
      n_set++;
    end
    if (bus.pulsed_up) begin
      if (n_up < 16) up_cy[n_up] = cyc;
      n_up++;
    end
    if (bus.pulsed_down) begin
      if (n_dn < 16) dn_cy[n_dn] = cyc;
      n_dn++;
    end
  endtask
  task automatic run(input int n);
    repeat (n) step();
  endtask
  task automatic clr();
    n_set = 0;
    n_up = 0;
    n_dn = 0;
  endtask
  task automatic align();
    for (int k = 0; k < 8 && cyc % 8 != 0; k++) step();
  endtask
  initial begin
    bus.btn_set = 1'b0;
    bus.btn_up = 1'b0;
    bus.btn_down = 1'b0;
    clr();
    run(3);
    reset = 1'b0;
    run(64);
    clr();
    repeat (3) begin
      bus.btn_set = 1'b1;
      run(3);
      bus.btn_set = 1'b0;
      run(2);
    end
    bus.btn_set = 1'b1;
    n0 = cyc;
    run(20);
    check("set_count", n_set, 1);
    check("set_at", set_cy[0], n0 + 7);
    clr();
    bus.btn_set = 1'b0;
    run(20);
    check("set_release", n_set, 0);
    clr();
    bus.btn_set = 1'b1;
    n0 = cyc;
    run(4);
    bus.btn_set = 1'b0;
    run(20);
    check("set_min_count", n_set, 1);
    check("set_min_at", set_cy[0], n0 + 7);
    align();
    clr();
    bus.btn_up = 1'b1;
    n0 = cyc;
    run(60);
    bus.btn_up = 1'b0;
    run(30);
    check("rep_count", n_up, 7);
    check("rep_press_at", up_cy[0], n0 + 7);
    check("rep_first_at", up_cy[1], n0 + 23);
    check("rep_second_at", up_cy[2], n0 + 31);
    check("rep_last_at", up_cy[6], n0 + 63);
    check("rep_no_down", n_dn, 0);
    align();
    clr();
    bus.btn_up = 1'b1;
    bus.btn_down = 1'b1;
    n0 = cyc;
    run(60);
    bus.btn_up = 1'b0;
    bus.btn_down = 1'b0;
    run(30);
    check("both_up_count", n_up, 1);
    check("both_dn_count", n_dn, 1);
    check("both_up_at", up_cy[0], n0 + 7);
    check("both_dn_at", dn_cy[0], n0 + 7);
    align();
    clr();
    bus.btn_down = 1'b1;
    n0 = cyc;
    run(34);
    check("pre_reset_count", n_dn, 3);
    check("pre_reset_rep_at", dn_cy[2], n0 + 31);
    reset = 1'b1;
    run(8);
    reset = 1'b0;
    clr();
    run(10);
    bus.btn_down = 1'b0;
    run(25);
    check("post_reset_count", n_dn, 1);
    check("post_reset_at", dn_cy[0], 7);
    clr();
    bus.btn_down = 1'b1;
    run(1);
    bus.btn_down = 1'b0;
    run(30);
    check("glitch_dn", n_dn, 0);
    check("glitch_up", n_up, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/button_tick_conditioner.md
# button_tick_conditioner

Front-end conditioning stage that feeds the clock display wrapper.
- Synchronises and debounces the raw set/up/down push buttons.
- Emits single-cycle `pulsed_set`, `pulsed_up` and `pulsed_down` strobes, with auto-repeat on up/down while held.
- Generates the `real_quarter` (4 Hz) and `real_clk` (1 Hz) timebase strobes from the system clock.

All outputs connect directly to the same-named wrapper inputs.

## Interface
- `DEBOUNCE_CYCLES`, default 500_000: clk cycles a synchronised input must hold a new level before it is accepted (10 ms at 50 MHz).
- `QUARTER_CYCLES`, default 12_500_000: clk cycles per quarter-second strobe.
- `HOLD_QUARTERS`, default 4: number of quarter strobes a button must be held before up/down auto-repeat begins.
- `clk`  in  1  system clock (all outputs change only on its rising edge).
- `reset`  in  1  asynchronous, active-high reset.
- `btn_set`  in  1  raw, asynchronous set button, active-high.
- `btn_up`  in  1  raw, asynchronous up button, active-high.
- `btn_down`  in  1  raw, asynchronous down button, active-high.
- `pulsed_set`  out  1  one-cycle strobe on an accepted set press.
- `pulsed_up`  out  1  one-cycle strobe on an accepted up press or an up repeat.
- `pulsed_down`  out  1  one-cycle strobe on an accepted down press or a down repeat.
- `real_quarter`  out  1  one-cycle strobe every `QUARTER_CYCLES` cycles.
- `real_clk`  out  1  one-cycle strobe on every 4th `real_quarter`; always coincident with that `real_quarter`.

## Operation
- **Synchroniser.** Each button passes through a 2-flop synchroniser. Reset value: 0.
- **Debounce.** One per button, with a `stable` bit (reset 0) and a counter of width `$clog2(DEBOUNCE_CYCLES)` (reset 0).
  - While synchronised input equals `stable`, the counter clears to 0.
  - Otherwise the counter increments. When it reaches `DEBOUNCE_CYCLES-1`, `stable` takes the new level and the counter clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles resets the count and is never accepted.
- **Press strobe.** Asserts for exactly one cycle, the cycle after `stable` rises 0→1. No strobe on release.
- **Timebase.**
  - `qcnt` counts 0..`QUARTER_CYCLES-1` and wraps to 0.
  - `real_quarter`=1 in the cycle `qcnt`==`QUARTER_CYCLES-1`.
  - 2-bit `qidx` increments on each strobe and wraps 3→0.
  - `real_clk`=1 when `real_quarter`=1 and `qidx`==3.
  - The timebase is free-running; buttons never affect it.
- **Auto-repeat FSM.** Separate instances for up and down; set has no repeat. States:
  - IDLE: on press strobe → HOLD, `hcnt`=0.
  - HOLD: each `real_quarter` increments `hcnt`. When `hcnt` reaches `HOLD_QUARTERS` → REPEAT, and one repeat strobe is emitted on that same quarter.
  - REPEAT: one repeat strobe on each `real_quarter`.
  - HOLD or REPEAT: `stable` falling → IDLE immediately, with no strobe in that cycle.
- **Output combine.** `pulsed_up`/`pulsed_down` = press strobe OR repeat strobe. Both sources never fire in the same cycle, because the press strobe only occurs from IDLE.
- **Simultaneous events.**
  - Up and down both `stable`=1: both repeat FSMs are forced to IDLE and produce no repeat strobes. Press strobes still fire independently.
  - All three buttons may strobe in the same cycle; there is no arbitration.
- **Reset mid-operation.** All state returns to its reset value and every output is 0 while reset is held. A button still held at reset release is treated as a fresh press: one strobe after debounce latency.

## Timing
- Reset values: all outputs 0; all counters 0; `qidx`=0; FSMs IDLE.
- **Press latency.** Raw level held from edge N:
  - `stable` rises at edge N+2+`DEBOUNCE_CYCLES`.
  - The strobe is high for the cycle after edge N+3+`DEBOUNCE_CYCLES`.
- **Release latency.** Same path: 2 synchroniser cycles + `DEBOUNCE_CYCLES` cycles.
- **First timebase strobe.** First `real_quarter` is high for the cycle after edge `QUARTER_CYCLES-1` following reset release; first `real_clk` is on the 4th quarter.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- **Shared package `clock_ui_pkg`:** repeat FSM state enum (IDLE, HOLD, REPEAT) and default timing constants.
- **Sub-module `debounce_oneshot`:** synchroniser + debounce + rising-edge strobe. Outputs `stable` and `press`; instantiated three times.
- The timebase and the two repeat FSMs live in the top level.

## Test plan
Run with `DEBOUNCE_CYCLES`=4, `QUARTER_CYCLES`=8, `HOLD_QUARTERS`=2.
1. **Timebase.** Release reset, run 64 cycles → `real_quarter` high for the cycle after edges 7, 15, 23, …; `real_clk` only with the 4th, 8th quarter; each strobe exactly 1 cycle.
2. **Bounce rejection.** `btn_set` toggles with 3-cycle highs, then holds steady → exactly one `pulsed_set`, 7 cycles after the steady rise. Release → no strobe.
3. **Auto-repeat.** Hold `btn_up` for 60 cycles → one press strobe, then repeat strobes starting on the 2nd `real_quarter` after the press and one per quarter after that. Release → strobes stop within 6 cycles.
4. **Simultaneous hold.** `btn_up` and `btn_down` rise together and are held 60 cycles → one `pulsed_up` and one `pulsed_down` in the same cycle, no repeats.
5. **Reset mid-hold.** Assert reset during REPEAT with `btn_down` still held → outputs 0 immediately. After release, one fresh `pulsed_down` 7 cycles later; the timebase restarts from `qcnt`=0.
6. **Glitch rejection.** 1-cycle `btn_down` glitch → no strobe and the FSM stays IDLE.
